pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the non-pipelined rv32 core.
- Sits directly downstream of branch_logic and consumes its b_out along with the jump decode.
- Holds the architectural PC and issues one instruction-memory request at a time over a req/ack handshake.
- Computes the next PC from sequential, branch, JAL or JALR resolution.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- XLEN, 32: address/data width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  core run enable; low parks the unit in IDLE after any in-flight fetch completes.
- b_out  input  1  branch-taken from branch_logic; valid in the cycle instr_valid=1.
- is_jal  input  1  current instruction is JAL; valid with instr_valid.
- is_jalr  input  1  current instruction is JALR; valid with instr_valid.
- imm  input  32  sign-extended immediate of the current instruction.
- rs1_data  input  32  rs1 register value, used for JALR.
- i_ack  input  1  instruction memory has returned data for i_addr.
- i_req  output  1  fetch request.
- i_addr  output  32  fetch address; always equals pc.
- pc  output  32  PC of the instruction currently fetched or executing.
- pc_plus4  output  32  pc+4, used for the JAL/JALR link value.
- instr_valid  output  1  one-cycle pulse; fetched instruction is present and resolves this cycle.
- misaligned_err  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, n_rst=0):
  - pc=RESET_VECTOR; state=IDLE.
  - i_req=0, instr_valid=0, misaligned_err=0.
  - Takes effect immediately, including mid-fetch: the request drops at once and any late i_ack is ignored.
- States are IDLE, FETCH, EXEC, HALT.
- IDLE:
  - i_req=0.
  - en=1 → FETCH next cycle.
- FETCH:
  - i_req=1; i_addr=pc held stable until ack.
  - i_ack=1 → EXEC.
  - en falling during FETCH does not cancel the request; the fetch completes normally.
- EXEC (exactly one cycle):
  - instr_valid=1, i_req=0.
  - b_out, is_jal, is_jalr, imm and rs1_data are sampled this cycle.
  - The PC register updates at the end of this cycle.
  - Next state: FETCH if en=1, else IDLE.
- i_ack while in IDLE, EXEC or HALT is ignored.
- Next-PC selection, priority high→low:
  - is_jalr → (rs1_data+imm) & ~32'h1.
  - is_jal → pc+imm.
  - b_out → pc+imm.
  - otherwise → pc+4.
  - is_jal and is_jalr both high: JALR wins.
- Arithmetic:
  - All adds are 32-bit, modulo 2^32; wrap is silent (pc=32'hFFFF_FFFC, sequential → 32'h0).
- pc_plus4:
  - Combinational pc+4, valid in every state.
- Outputs are registered state decodes; no combinational path from i_ack to i_req.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In EXEC, a selected next-PC with bit1=1 does not update pc.
  - misaligned_err is set and stays sticky until reset.
  - State → HALT, where i_req=0 and instr_valid=0 until reset.
- Undefined:
  - Bits [1:0] of the next PC are forced to 0.
  - HALT is unreachable and misaligned_err is tied 0.

Test Plan:
- Reset, then en=1 with i_ack returned in the same cycle as i_req → i_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle.
- pc=0x100, imm=0xFFFFFFF0, b_out=1 in EXEC → next i_addr=0xF0. Same stimulus with b_out=0 → next i_addr=0x104.
- pc=0x200, is_jalr=1, is_jal=1, rs1_data=0x1001, imm=4 → next pc=0x1004 (JALR wins, bit0 cleared); pc_plus4=0x204 during EXEC.
- i_ack delayed 5 cycles with en dropped in cycle 2 → i_req and i_addr held until ack, then one EXEC pulse, then IDLE with pc advanced. Reasserting en restarts fetch.
- n_rst asserted mid-FETCH at pc=0x40 → i_req=0 the same cycle, pc=RESET_VECTOR; a stray i_ack after release produces no instr_valid.
- pc=0x0, is_jal=1, imm=0x6:
  - with MISALIGN_TRAP_EN → misaligned_err=1, pc stays 0x0, HALT with no further i_req;
  - without it → next pc=0x4.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer for the
// non-pipelined rv32 core. Optional misaligned-target trap: MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            en,
  input  logic            b_out,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            i_ack,
  output logic            i_req,
  output logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            misaligned_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  typedef struct packed {
    logic            b_out;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
  } resolve_t;

  state_t          state, state_nxt;
  resolve_t        res;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] jalr_sum, rel_tgt, seq_tgt, sel_tgt;
  logic            pc_we;
  logic            trap;

  assign res = '{b_out: b_out, is_jal: is_jal, is_jalr: is_jalr,
                 imm: imm, rs1: rs1_data};

  // Target adders are all modulo 2^XLEN; overflow wraps silently.
  assign jalr_sum = res.rs1 + res.imm;
  assign rel_tgt  = pc_q + res.imm;
  assign seq_tgt  = pc_q + XLEN'(4);

  always_comb begin
    sel_tgt = seq_tgt;
    if (res.is_jalr)     sel_tgt = jalr_sum & ~XLEN'(1);
    else if (res.is_jal) sel_tgt = rel_tgt;
    else if (res.b_out)  sel_tgt = rel_tgt;
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign trap   = sel_tgt[1];
  assign pc_nxt = sel_tgt;

  // Sticky until reset; only set on the EXEC cycle that selects a bad target.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     err_q <= 1'b0;
    else if (state == EXEC && trap) err_q <= 1'b1;
  end

  assign misaligned_err = err_q;
`else
  assign trap           = 1'b0;
  assign pc_nxt         = sel_tgt & ~XLEN'(3);
  assign misaligned_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_we     = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = FETCH;
      FETCH: if (i_ack) state_nxt = EXEC;
      EXEC: begin
        if (trap) begin
          state_nxt = HALT;
        end else begin
          pc_we     = 1'b1;
          state_nxt = en ? FETCH : IDLE;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      pc_q  <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      if (pc_we) pc_q <= pc_nxt;
    end
  end

  // Handshake outputs decode the registered state only, so i_ack never
  // reaches i_req combinationally.
  assign i_req       = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign pc          = pc_q;
  assign i_addr      = pc_q;
  assign pc_plus4    = seq_tgt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: chained next-PC vector table plus
// hand-written reset, stalled-ack and misaligned-target sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic        b_out = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic [31:0] imm = '0, rs1_data = '0;
  logic        i_ack = 1'b0;
  logic        i_req, instr_valid, misaligned_err;
  logic [31:0] i_addr, pc, pc_plus4;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_VECTOR(32'h0), .XLEN(32)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .b_out(b_out), .is_jal(is_jal),
    .is_jalr(is_jalr), .imm(imm), .rs1_data(rs1_data), .i_ack(i_ack),
    .i_req(i_req), .i_addr(i_addr), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        b_out, is_jal, is_jalr;
    logic [31:0] imm, rs1;
    logic [31:0] pc;       // pc while this instruction is fetched/executed
    logic [31:0] pc_next;  // expected pc after its EXEC cycle
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (i_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req_timeout"}, 32'(i_req), 32'd1);
  endtask

  task automatic clear_dec();
    b_out = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; imm = '0; rs1_data = '0;
  endtask

  // Acks in the same cycle as the request, so each instruction takes 2 cycles.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_req(tag);
    chk({tag, "_i_addr"}, i_addr, v.pc);
    i_ack = 1'b1;
    b_out = v.b_out; is_jal = v.is_jal; is_jalr = v.is_jalr;
    imm = v.imm; rs1_data = v.rs1;
    @(negedge clk);
    i_ack = 1'b0;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, pc, v.pc);
    chk({tag, "_pc_plus4"}, pc_plus4, v.pc + 32'd4);
    @(negedge clk);
    clear_dec();
    chk({tag, "_pc_next"}, pc, v.pc_next);
    chk({tag, "_refetch"}, 32'(i_req), 32'd1);
    chk({tag, "_valid_low"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    //           b  jal jalr imm            rs1            pc             pc_next
    vecs[0]  = '{0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h4};
    vecs[1]  = '{0, 0, 0, 32'h0,          32'h0,         32'h4,         32'h8};
    vecs[2]  = '{0, 1, 0, 32'hF8,         32'h0,         32'h8,         32'h100};
    vecs[3]  = '{1, 0, 0, 32'hFFFF_FFF0,  32'h0,         32'h100,       32'hF0};
    vecs[4]  = '{0, 1, 0, 32'h10,         32'h0,         32'hF0,        32'h100};
    vecs[5]  = '{0, 0, 0, 32'hFFFF_FFF0,  32'h0,         32'h100,       32'h104};
    vecs[6]  = '{0, 0, 1, 32'h0,          32'h200,       32'h104,       32'h200};
    vecs[7]  = '{0, 1, 1, 32'h4,          32'h1001,      32'h200,       32'h1004};
    vecs[8]  = '{0, 0, 1, 32'hC,          32'hFFFF_FFF0, 32'h1004,      32'hFFFF_FFFC};
    vecs[9]  = '{0, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 32'h0};
    vecs[10] = '{0, 0, 1, 32'h0,          32'h40,        32'h0,         32'h40};

    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_i_req", 32'(i_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(misaligned_err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    en = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Async reset mid-FETCH at pc=0x40
    chk("prerst_req", 32'(i_req), 32'd1);
    chk("prerst_addr", i_addr, 32'h40);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_req", 32'(i_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    @(negedge clk);
    en = 1'b0;
    n_rst = 1'b1;
    i_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_ack_valid", 32'(instr_valid), 32'd0);
      chk("stray_ack_req", 32'(i_req), 32'd0);
    end
    i_ack = 1'b0;

    // Ack delayed 5 cycles, en dropped during the fetch
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", 32'(i_req), 32'd1);
      chk("stall_addr", i_addr, 32'h0);
      if (k == 1) en = 1'b0;
      @(negedge clk);
    end
    chk("stall_req_end", 32'(i_req), 32'd1);
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    chk("stall_exec", 32'(instr_valid), 32'd1);
    @(negedge clk);
    chk("stall_idle_req", 32'(i_req), 32'd0);
    chk("stall_idle_valid", 32'(instr_valid), 32'd0);
    chk("stall_pc", pc, 32'h4);
    @(negedge clk);
    chk("idle_hold_req", 32'(i_req), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("restart_req", 32'(i_req), 32'd1);
    chk("restart_addr", i_addr, 32'h4);

    // Misaligned JAL target from pc=0
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    wait_req("mis");
    chk("mis_addr", i_addr, 32'h0);
    i_ack = 1'b1;
    is_jal = 1'b1;
    imm = 32'h6;
    @(negedge clk);
    i_ack = 1'b0;
    chk("mis_exec", 32'(instr_valid), 32'd1);
    @(negedge clk);
    clear_dec();
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", 32'(misaligned_err), 32'd1);
    chk("mis_pc", pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("halt_req", 32'(i_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_err", 32'(misaligned_err), 32'd1);
      @(negedge clk);
    end
`else
    chk("mis_err", 32'(misaligned_err), 32'd0);
    chk("mis_pc", pc, 32'h4);
    chk("mis_req", 32'(i_req), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
